// File: rtl/approx_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_add_pkg
//  Description : Shared helpers for the pipelined approximate adder: stage
//                count, saturating arithmetic and the lower-part-OR
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_add_pkg;

    // Number of pipeline segments needed to cover w bits in seg_w-bit chunks.
    function automatic int calc_stages(input int w, input int seg_w);
        return (w + seg_w - 1) / seg_w;
    endfunction

    // Saturating add of two unsigned values, clamped to a width-bit all-ones.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          width);
        logic [63:0] lim;
        logic [64:0] s;
        lim = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        s   = {1'b0, acc} + {1'b0, inc};
        if (s[64] || (s[63:0] > lim)) begin
            return lim;
        end
        return s[63:0];
    endfunction

    // Saturating increment by one.
    function automatic logic [63:0] sat_inc(input logic [63:0] acc,
                                            input int          width);
        return sat_add(acc, 64'd1, width);
    endfunction

    // Lower-part-OR adder: low k bits are a|b, the carry into bit k is
    // a[k-1]&b[k-1], the upper part is an exact add. Exact when k==0 or
    // approximation is disabled. Operands are zero-extended, so the result
    // width follows the operand width plus one carry bit.
    function automatic logic [63:0] loa_sum(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          k,
                                            input logic        approx_en);
        logic [63:0] mask;
        logic [63:0] low;
        logic [63:0] c;
        if (!approx_en || (k == 0)) begin
            return a + b;
        end
        mask = (64'd1 << k) - 64'd1;
        low  = (a | b) & mask;
        c    = (a >> (k - 1)) & (b >> (k - 1)) & 64'd1;
        return (((a >> k) + (b >> k) + c) << k) | low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_add_seg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_add_seg
//  Description : Combinational SEG_W-bit segment of the approximate adder.
//                Bits flagged in i_approx_mask produce a|b and hand a&b on as
//                the carry; other bits are ordinary full adders.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_add_seg
    import approx_add_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic [SEG_W-1:0] i_approx_mask,
    input  logic             i_cin,
    output logic [SEG_W-1:0] o_sum,
    output logic             o_cout
);

    // Ripple through the segment; an approximate bit ignores its incoming
    // carry, so only the top approximate bit's a&b reaches an exact bit.
    always_comb begin
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < SEG_W; i++) begin
            if (i_approx_mask[i]) begin
                o_sum[i] = i_a[i] | i_b[i];
                w_c      = i_a[i] & i_b[i];
            end else begin
                o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
                w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
            end
        end
        o_cout = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : approx_add_pipe
//  Description : Pipelined, segmented lower-part-OR approximate adder with a
//                valid/ready stream interface and per-beat exact/approx mode.
//                Optional error monitor enabled by APPROX_ADD_ERRMON_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int W     = 8,
    parameter int K     = 2,
    parameter int SEG_W = 4,
    parameter int ERR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       sum,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_sum,
    output logic [W:0]       err_max,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int N  = calc_stages(W, SEG_W);
    localparam int WP = N * SEG_W;

    logic              w_adv;
    logic [WP-1:0]     w_a_pad;
    logic [WP-1:0]     w_b_pad;
    logic [N-1:0]      valid_d,  valid_q;
    logic [N-1:0]      carry_d,  carry_q;
    logic [N-1:0]      approx_d, approx_q;
    logic [WP-1:0]     opa_d [N];
    logic [WP-1:0]     opa_q [N];
    logic [WP-1:0]     opb_d [N];
    logic [WP-1:0]     opb_q [N];
    logic [WP-1:0]     psum_d[N];
    logic [WP-1:0]     psum_q[N];
    logic [WP:0]       w_full;
    logic              w_unused;

    // Single global stall: every stage moves together or not at all.
    assign w_adv    = out_ready | ~valid_q[N-1];
    assign in_ready = w_adv;
    assign w_a_pad  = WP'(a);
    assign w_b_pad  = WP'(b);

    for (genvar j = 0; j < N; j++) begin : g_stage
        logic [WP-1:0]    w_a_in, w_b_in, w_s_in;
        logic             w_c_in, w_v_in, w_x_in;
        logic [SEG_W-1:0] w_mask, w_seg_s;
        logic             w_seg_c;

        if (j == 0) begin : g_first
            assign w_a_in = w_a_pad;
            assign w_b_in = w_b_pad;
            assign w_s_in = '0;
            assign w_c_in = 1'b0;
            assign w_v_in = in_valid;
            assign w_x_in = approx_en;
        end else begin : g_next
            assign w_a_in = opa_q[j-1];
            assign w_b_in = opb_q[j-1];
            assign w_s_in = psum_q[j-1];
            assign w_c_in = carry_q[j-1];
            assign w_v_in = valid_q[j-1];
            assign w_x_in = approx_q[j-1];
        end

        // Bits of this segment below K are approximated when the beat asks.
        for (genvar i = 0; i < SEG_W; i++) begin : g_mask
            assign w_mask[i] = w_x_in & ((j * SEG_W + i) < K);
        end

        approx_add_seg #(.SEG_W(SEG_W)) u_seg (
            .i_a           (w_a_in[j*SEG_W +: SEG_W]),
            .i_b           (w_b_in[j*SEG_W +: SEG_W]),
            .i_approx_mask (w_mask),
            .i_cin         (w_c_in),
            .o_sum         (w_seg_s),
            .o_cout        (w_seg_c)
        );

        // Earlier stages only ever fill bits below this segment, so OR-ing in
        // the new segment is an overlay.
        assign psum_d[j]   = w_s_in | (WP'(w_seg_s) << (j * SEG_W));
        assign opa_d[j]    = w_a_in;
        assign opb_d[j]    = w_b_in;
        assign carry_d[j]  = w_seg_c;
        assign valid_d[j]  = w_v_in;
        assign approx_d[j] = w_x_in;
    end

    // Pipeline registers, valid bits included, advance only on w_adv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            carry_q  <= '0;
            approx_q <= '0;
            for (int j = 0; j < N; j++) begin
                opa_q[j]  <= '0;
                opb_q[j]  <= '0;
                psum_q[j] <= '0;
            end
        end else if (w_adv) begin
            valid_q  <= valid_d;
            carry_q  <= carry_d;
            approx_q <= approx_d;
            for (int j = 0; j < N; j++) begin
                opa_q[j]  <= opa_d[j];
                opb_q[j]  <= opb_d[j];
                psum_q[j] <= psum_d[j];
            end
        end
    end

    // Carry into bit W lands in the padding bit when WP>W, otherwise in the
    // final carry register; either way it is bit W of w_full.
    assign w_full    = {carry_q[N-1], psum_q[N-1]};
    assign sum       = w_full[W:0];
    assign out_valid = valid_q[N-1];

    // Last-stage operands and mode are consumed before the final register.
    assign w_unused = ^{opa_q[N-1], opb_q[N-1], approx_q[N-1], w_full};

`ifdef APPROX_ADD_ERRMON_EN
    logic [W:0]       exact_d[N];
    logic [W:0]       exact_q[N];
    logic [W:0]       w_diff;
    logic [ERR_W-1:0] err_sum_d, err_sum_q;
    logic [W:0]       err_max_d, err_max_q;
    logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

    assign exact_d[0] = {1'b0, a} + {1'b0, b};
    for (genvar j = 1; j < N; j++) begin : g_exact
        assign exact_d[j] = exact_q[j-1];
    end

    // Shadow exact sum travels in lockstep with the segmented pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                exact_q[j] <= '0;
            end
        end else if (w_adv) begin
            for (int j = 0; j < N; j++) begin
                exact_q[j] <= exact_d[j];
            end
        end
    end

    assign w_diff = (exact_q[N-1] >= sum) ? (exact_q[N-1] - sum) : (sum - exact_q[N-1]);

    // Statistics update on the output handshake; a coincident clear wins.
    always_comb begin
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_sum_d = '0;
            err_max_d = '0;
            err_cnt_d = '0;
        end else if (valid_q[N-1] && out_ready) begin
            err_sum_d = ERR_W'(sat_add(64'(err_sum_q), 64'(w_diff), ERR_W));
            if (w_diff > err_max_q) begin
                err_max_d = w_diff;
            end
            if (w_diff != '0) begin
                err_cnt_d = ERR_W'(sat_inc(64'(err_cnt_q), ERR_W));
            end
        end
    end

    // Error statistic registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum_q <= '0;
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sum = err_sum_q;
    assign err_max = err_max_q;
    assign err_cnt = err_cnt_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_sum = '0;
    assign err_max = '0;
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_add_pipe
//  Description : Directed self-checking bench for approx_add_pipe: an
//                W=8/K=2/SEG_W=4 instance plus W=16/SEG_W=3 instances with
//                K=5 and K=0. Error-monitor expectations follow
//                APPROX_ADD_ERRMON_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_add_pipe;
    import approx_add_pkg::*;

`ifdef APPROX_ADD_ERRMON_EN
    localparam logic [63:0] EM = 64'd1;
`else
    localparam logic [63:0] EM = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        in_valid8 = 1'b0, approx8 = 1'b0, out_ready8 = 1'b1, clr8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8;
    logic [8:0]  sum8, max8;
    logic [31:0] esum8, ecnt8;

    approx_add_pipe #(.W(8), .K(2), .SEG_W(4), .ERR_W(32)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .approx_en(approx8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .err_clr(clr8),
        .err_sum(esum8), .err_max(max8), .err_cnt(ecnt8));

    // 16-bit instances share stimulus
    logic        in_valid16 = 1'b0, approx16 = 1'b0, out_ready16 = 1'b1, clr16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, in_ready16e, out_valid16e;
    logic [16:0] sum16, sum16e, max16, max16e;
    logic [31:0] esum16, ecnt16, esum16e, ecnt16e;

    approx_add_pipe #(.W(16), .K(5), .SEG_W(3), .ERR_W(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .approx_en(approx16), .out_valid(out_valid16),
        .out_ready(out_ready16), .sum(sum16), .err_clr(clr16),
        .err_sum(esum16), .err_max(max16), .err_cnt(ecnt16));

    approx_add_pipe #(.W(16), .K(0), .SEG_W(3), .ERR_W(32)) dut16e (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16e),
        .a(a16), .b(b16), .approx_en(approx16), .out_valid(out_valid16e),
        .out_ready(out_ready16), .sum(sum16e), .err_clr(clr16),
        .err_sum(esum16e), .err_max(max16e), .err_cnt(ecnt16e));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [16:0] s; logic [16:0] e; int c; } exp16_t;
    exp16_t      q16[$];
    logic [8:0]  q8[$];

    initial begin
        int          sent, got, seen;
        logic        prev_stall;
        logic [8:0]  prev_sum, exp8;
        exp16_t      ent;

        // ---------------- reset state ----------------
        #23 rst = 1'b0;
        step();
        check("rst_out_valid", out_valid8, 0);
        check("rst_sum", sum8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_err_sum", esum8, 0);
        check("rst_err_max", max8, 0);
        check("rst_err_cnt", ecnt8, 0);

        // ---------------- 0x03 + 0x01 approx -> 0x003, latency 2 ----------------
        in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h01; approx8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        check("lat_early_valid", out_valid8, 0);
        step();
        check("lat_valid", out_valid8, 1);
        check("sum_03_01", sum8, 9'h003);
        step();
        check("err_sum_a", esum8, EM * 1);
        check("err_cnt_a", ecnt8, EM * 1);
        check("err_max_a", max8, EM * 1);

        // idle clear
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
        check("clr_idle_sum", esum8, 0);
        check("clr_idle_cnt", ecnt8, 0);

        // ---------------- 0xFF+0x01 -> 0x0FF, 0xFF+0xFF -> 0x1FF ----------------
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        step();
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        in_valid8 = 1'b0;
        check("sum_ff_01", sum8, 9'h0FF);
        step();
        check("sum_ff_ff_approx", sum8, 9'h1FF);
        step();
        check("err_sum_b", esum8, EM * 2);
        check("err_max_b", max8, EM * 1);
        check("err_cnt_b", ecnt8, EM * 2);

        // ---------------- exact mode 0xFF+0xFF -> 0x1FE ----------------
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; approx8 = 1'b0;
        step();
        in_valid8 = 1'b0;
        step();
        check("sum_ff_ff_exact", sum8, 9'h1FE);
        step();
        check("err_cnt_exact", ecnt8, EM * 2);
        check("err_sum_exact", esum8, EM * 2);

        // ---------------- clear coinciding with handshake ----------------
        in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h01; approx8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        check("clr_hs_valid", out_valid8, 1);
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
        check("clr_hs_sum", esum8, 0);
        check("clr_hs_cnt", ecnt8, 0);
        check("clr_hs_max", max8, 0);

        // ---------------- 16-beat stream with 5-cycle stall ----------------
        sent = 0; got = 0; prev_stall = 1'b0; prev_sum = '0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            @(posedge clk); #1;
            if (prev_stall) check("stall_hold", sum8, prev_sum);
            out_ready8 = !(cyc >= 6 && cyc < 11);
            if (sent < 16) begin
                in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); approx8 = 1'($urandom);
            end else begin
                in_valid8 = 1'b0;
            end
            #1;
            if (out_valid8 && !out_ready8 && !prev_stall) check("stall_in_ready", in_ready8, 0);
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    check("stream_spurious_valid", out_valid8, 0);
                end else begin
                    exp8 = q8.pop_front();
                    check("stream_sum", sum8, exp8);
                    got++;
                end
            end
            if (in_valid8 && in_ready8) begin
                q8.push_back(9'(loa_sum(64'(a8), 64'(b8), 2, approx8)));
                sent++;
            end
            prev_stall = out_valid8 && !out_ready8;
            prev_sum   = sum8;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        check("stream_count", got, 16);

        // ---------------- async reset with two beats in flight ----------------
        step();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h20; approx8 = 1'b1;
        step();
        a8 = 8'h30; b8 = 8'h01;
        step();
        in_valid8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid8, 0);
        check("rst_async_sum", sum8, 0);
        #3 rst = 1'b0;
        out_ready8 = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid8) seen++;
        end
        check("rst_no_ghost", seen, 0);
        check("rst_in_ready", in_ready8, 1);

        // ---------------- W=16 K=5 SEG_W=3, and K=0 ----------------
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 1300 && got < 1000; cyc++) begin
            @(posedge clk); #1;
            if (sent < 1000) begin
                in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); approx16 = 1'($urandom);
            end else begin
                in_valid16 = 1'b0;
            end
            #1;
            if (out_valid16) begin
                if (q16.size() == 0) begin
                    check("w16_spurious_valid", out_valid16, 0);
                end else begin
                    ent = q16.pop_front();
                    check("w16_sum", sum16, ent.s);
                    check("w16_k0_valid", out_valid16e, 1);
                    check("w16_k0_exact", sum16e, ent.e);
                    check("w16_latency", 64'(cyc - ent.c), 6);
                    got++;
                end
            end
            if (in_valid16 && in_ready16) begin
                ent.s = 17'(loa_sum(64'(a16), 64'(b16), 5, approx16));
                ent.e = {1'b0, a16} + {1'b0, b16};
                ent.c = cyc;
                q16.push_back(ent);
                sent++;
            end
        end
        in_valid16 = 1'b0;
        check("w16_count", got, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/approx_add_pipe.md
# approx_add_pipe

Parametrised, pipelined approximate adder for the 8-bit approximate adder library's next generation. Operand width and the number of approximated low bits are parameters. The adder is segmented into registered carry-chunks behind a valid/ready stream interface, and exact/approximate mode is selectable per transaction. It sits in datapaths that consume approximate sums, such as accumulators and filter taps, and can optionally monitor its own arithmetic error.

## Interface
- `W`, 8: operand width, ≥2
- `K`, 2: approximated low bits, 0..W
- `SEG_W`, 4: carry-chain bits per pipeline segment, 1..W; stage count `N = ceil(W/SEG_W)`
- `ERR_W`, 32: error accumulator width
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: operand beat accepted when `in_valid & in_ready`
- `a`, `b` in W: operands, unsigned
- `approx_en` in 1: 1 = approximate, 0 = exact; travels with the beat
- `out_valid` out 1: result valid
- `out_ready` in 1: downstream accepts
- `sum` out W+1: result, including carry-out
- `err_clr` in 1: synchronous clear of the error statistics
- `err_sum` out ERR_W: saturating sum of |exact − approx|
- `err_max` out W+1: maximum |exact − approx| observed
- `err_cnt` out ERR_W: saturating count of beats with nonzero error

## Operation
- **Approximate, `approx_en=1` and K>0:**
  - bits below K: `sum[i] = a[i] | b[i]`
  - carry into bit K: `a[K-1] & b[K-1]`
  - bits K..W−1 and `sum[W]`: exact ripple add of the upper parts plus that carry
- **Exact:** if `approx_en=0` or K=0, `sum = a + b`, W+1 bits, no truncation.
- **Pipeline segmentation:**
  - segment j covers bits [j·SEG_W, min((j+1)·SEG_W, W)−1]
  - stage j adds segment j using the carry registered from stage j−1
  - not-yet-added operand bits and already-produced sum bits are carried forward in registers
  - the approximate low part is computed in the stage that owns those bits
- **Flow control:**
  - global stall: `adv = out_ready | ~out_valid`, and `in_ready = adv`
  - every stage, including its valid bit, loads only when `adv=1`
  - bubbles propagate as invalid stages and are not compressed
- **Ordering:** results leave in acceptance order, one per accepted beat. No reordering, no drops.
- **`sum` stability:** while `out_valid=1` and `out_ready=0`, `sum` holds stable.

## Timing
- **Latency:** exactly N cycles from acceptance to `out_valid` with no stall. W=8, SEG_W=4 gives N=2.
- **Throughput:** 1 beat/cycle while `out_ready=1`.
- **Reset values:**
  - all stage valids, `out_valid`, `sum`, `err_sum`, `err_max`, `err_cnt` are 0
  - `in_ready` is 1 once `rst` deasserts, since `out_valid=0`
- **Reset mid-operation:** in-flight beats are discarded and no partial result is emitted.
- **Error statistics update:** on the output handshake (`out_valid & out_ready`), registered.
- **`err_clr` vs handshake:** if `err_clr` coincides with a handshake, clear wins and that beat is not counted.
- **Saturation:** `err_sum` and `err_cnt` saturate at all-ones and do not wrap.

## Configuration
- **`APPROX_ADD_ERRMON_EN` defined:**
  - a parallel exact sum is carried through the pipeline, either a shadow segment chain or `a+b` registered N deep
  - |difference| drives `err_sum`, `err_max` and `err_cnt`
- **Undefined:**
  - the shadow path and the counters are not built
  - `err_sum`, `err_max`, `err_cnt` are tied to 0 and `err_clr` is ignored
  - ports remain so the interface is unchanged

## Structure
- **Package `approx_add_pkg`:**
  - function computing N from W and SEG_W
  - saturating-increment function
  - reference model function `loa_sum(a, b, K, approx_en)` shared by RTL assertions and the bench
- **Sub-module:** one natural sub-module, `approx_add_seg`, the combinational SEG_W-bit segment adder with carry-in, carry-out and approximate-bit mask input. The top level instantiates N of them plus the pipeline registers.

## Test plan
- W=8, K=2, SEG_W=4, `approx_en=1`, a=0x03, b=0x01 → `sum`=0x003 two cycles after accept; with ERRMON, `err_sum`=1, `err_cnt`=1, `err_max`=1.
- Same config, a=0xFF, b=0x01 → 0x0FF. Then a=0xFF, b=0xFF → 0x1FF (exact 0x1FE); after both beats, `err_sum`=2, `err_max`=1.
- `approx_en=0`, a=0xFF, b=0xFF → 0x1FE. With ERRMON, `err_cnt` is unchanged.
- Streaming and stalls:
  - stream 16 random beats back-to-back with `out_ready` held low for 5 cycles mid-stream
  - `in_ready` drops in the cycle after `out_valid` rises with `out_ready` low
  - `sum` holds while stalled, and all 16 results match `loa_sum` in order
- Reset and clear:
  - assert `rst` asynchronously with 2 beats in flight → `out_valid`=0 immediately, neither beat appears after release
  - `err_clr` pulsed on a handshake cycle → counters read 0 the next cycle
- W=16, K=5, SEG_W=3 (N=6): 1000 random beats match `loa_sum` with latency 6. K=0 gives exact results for every beat.
